// File: rtl/ssemi_adc_decimator_out_fifo.sv
// FWFT output buffer behind the decimator: level/watermark reporting,
// overflow detection and a saturating drop counter, single clock domain.
module ssemi_adc_decimator_out_fifo #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned DEPTH        = 16,
  parameter bit          DROP_ON_FULL = 1'b1,
  localparam int unsigned LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_decim_valid,
  input  logic [DATA_WIDTH-1:0] i_decim_data,
  output logic                  o_decim_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  input  logic                  i_flush,
  input  logic [LVL_W-1:0]      i_watermark,
  output logic [LVL_W-1:0]      o_level,
  output logic                  o_watermark_irq,
  output logic                  o_overflow,
  input  logic                  i_overflow_clr,
  output logic [15:0]           o_drop_count
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ready_q, ready_d;
  logic                  irq_q, irq_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic full_c, push_c, pop_c, drop_c, bypass_c;

  // Flush discards both the push and the pop of its cycle; a full FIFO
  // never accepts a write, even when a pop frees a slot in the same cycle.
  always_comb begin
    full_c   = (level_q == FULL_LVL);
    push_c   = i_decim_valid && !full_c && !i_flush;
    pop_c    = rd_valid_q && i_rd_ready && !i_flush;
    drop_c   = DROP_ON_FULL && i_decim_valid && full_c && !i_flush;
    // The incoming sample becomes the head when nothing else remains after the pop.
    bypass_c = push_c && (level_q == LVL_W'(pop_c));
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    ready_d    = 1'b1;
    irq_d      = 1'b0;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // Head is registered so o_rd_data is a flop and reads zero when empty.
    rd_valid_d = (level_d != '0);
    if (!rd_valid_d)   rd_data_d = '0;
    else if (bypass_c) rd_data_d = i_decim_data;
    else               rd_data_d = mem_q[rd_ptr_d];

    ready_d = DROP_ON_FULL ? 1'b1 : (level_d != FULL_LVL);
    irq_d   = (i_watermark != '0) && (level_d >= i_watermark);

    ovf_d = drop_c || (ovf_q && !i_overflow_clr);
    if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ready_q    <= 1'b1;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= i_decim_data;
  end

  assign o_decim_ready   = ready_q;
  assign o_rd_valid      = rd_valid_q;
  assign o_rd_data       = rd_data_q;
  assign o_level         = level_q;
  assign o_watermark_irq = irq_q;
  assign o_overflow      = ovf_q;
  assign o_drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_ssemi_adc_decimator_out_fifo.sv
// Directed bench: drop-mode and backpressure-mode instances share stimulus.
module tb_ssemi_adc_decimator_out_fifo;

  localparam int unsigned DW = 24;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          rd_ready = 1'b0;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [LW-1:0] wm = '0;

  logic          d_ready, d_vld, d_irq, d_ovf;
  logic [DW-1:0] d_data;
  logic [LW-1:0] d_lvl;
  logic [15:0]   d_drop;
  logic          b_ready, b_vld, b_irq, b_ovf;
  logic [DW-1:0] b_data;
  logic [LW-1:0] b_lvl;
  logic [15:0]   b_drop;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ssemi_adc_decimator_out_fifo u_drop (
    .i_clk(clk), .i_rst_n(rst_n), .i_decim_valid(valid), .i_decim_data(data),
    .o_decim_ready(d_ready), .o_rd_valid(d_vld), .o_rd_data(d_data),
    .i_rd_ready(rd_ready), .i_flush(flush), .i_watermark(wm), .o_level(d_lvl),
    .o_watermark_irq(d_irq), .o_overflow(d_ovf), .i_overflow_clr(ovf_clr),
    .o_drop_count(d_drop)
  );

  ssemi_adc_decimator_out_fifo #(.DROP_ON_FULL(1'b0)) u_bp (
    .i_clk(clk), .i_rst_n(rst_n), .i_decim_valid(valid), .i_decim_data(data),
    .o_decim_ready(b_ready), .o_rd_valid(b_vld), .o_rd_data(b_data),
    .i_rd_ready(rd_ready), .i_flush(flush), .i_watermark(wm), .o_level(b_lvl),
    .o_watermark_irq(b_irq), .o_overflow(b_ovf), .i_overflow_clr(ovf_clr),
    .o_drop_count(b_drop)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rr;
    logic          fl;
    logic [LW-1:0] wm;
    logic [LW-1:0] lvl;
    logic          vld;
    logic [DW-1:0] hd;
    logic          irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic rr, logic fl,
                              logic [LW-1:0] w, logic [LW-1:0] lvl, logic vld,
                              logic [DW-1:0] hd, logic irq);
    vec_t r;
    r.v = v; r.d = d; r.rr = rr; r.fl = fl; r.wm = w;
    r.lvl = lvl; r.vld = vld; r.hd = hd; r.irq = irq;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, settle to sample point.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rr,
                     input logic fl, input logic clr);
    valid = v; data = d; rd_ready = rr; flush = fl; ovf_clr = clr;
    @(posedge clk);
    #1;
    valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];

    // Ordering, watermark and flush rows
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, DW'(i + 1), 0, 0, 0, LW'(i + 1), 1, 24'h1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, LW'(4 - i), 1, DW'(i + 2), 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, DW'(24'h10 + i), 0, 0, 8, LW'(i + 1), 1, 24'h10, (i == 7)));
    tbl.push_back(mk(0, 0, 1, 0, 8, 7, 1, 24'h11, 0));
    tbl.push_back(mk(1, 24'h18, 0, 0, 8, 8, 1, 24'h11, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8, 1, 24'h11, 0));
    tbl.push_back(mk(1, 24'h99, 1, 1, 8, 0, 0, 0, 0));

    // Reset values, checked while reset is held
    #12;
    chk("rst_level", 32'(d_lvl), 0);
    chk("rst_rd_valid", 32'(d_vld), 0);
    chk("rst_rd_data", 32'(d_data), 0);
    chk("rst_ready_drop", 32'(d_ready), 1);
    chk("rst_ready_bp", 32'(b_ready), 1);
    chk("rst_irq", 32'(d_irq), 0);
    chk("rst_ovf", 32'(d_ovf), 0);
    chk("rst_drop", 32'(d_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      wm = tbl[i].wm;
      cyc(tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].fl, 1'b0);
      chk($sformatf("vec%0d_level", i), 32'(d_lvl), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_rd_valid", i), 32'(d_vld), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_rd_data", i), 32'(d_data), 32'(tbl[i].hd));
      chk($sformatf("vec%0d_irq", i), 32'(d_irq), 32'(tbl[i].irq));
      chk($sformatf("vec%0d_drop", i), 32'(d_drop), 0);
      chk($sformatf("vec%0d_bp_level", i), 32'(b_lvl), 32'(tbl[i].lvl));
    end
    wm = '0;

    // Drop on full / backpressure
    do_reset();
    for (int i = 1; i <= 20; i++) cyc(1, DW'(i), 0, 0, 0);
    chk("full_level", 32'(d_lvl), 16);
    chk("full_ovf", 32'(d_ovf), 1);
    chk("full_drop", 32'(d_drop), 4);
    chk("full_head", 32'(d_data), 1);
    chk("bp_full_level", 32'(b_lvl), 16);
    chk("bp_full_ready", 32'(b_ready), 0);
    chk("bp_full_ovf", 32'(b_ovf), 0);
    chk("drop_ready", 32'(d_ready), 1);
    cyc(1, 24'd21, 0, 0, 1);
    chk("clr_set_wins_ovf", 32'(d_ovf), 1);
    chk("clr_set_wins_drop", 32'(d_drop), 5);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(d_ovf), 0);
    chk("clr_keeps_drop", 32'(d_drop), 5);
    cyc(0, 0, 1, 0, 0);
    chk("pop1_level", 32'(d_lvl), 15);
    chk("pop1_head", 32'(d_data), 2);
    chk("bp_pop1_ready", 32'(b_ready), 1);
    chk("bp_pop1_drop", 32'(b_drop), 0);
    cyc(1, 24'h21, 0, 0, 0);
    chk("refill_level", 32'(d_lvl), 16);
    chk("refill_drop", 32'(d_drop), 5);
    chk("bp_refill_ready", 32'(b_ready), 0);
    cyc(1, 24'h22, 1, 0, 0);
    chk("full_pp_level", 32'(d_lvl), 15);
    chk("full_pp_drop", 32'(d_drop), 6);
    chk("bp_full_pp_level", 32'(b_lvl), 15);
    chk("bp_full_pp_drop", 32'(b_drop), 0);
    for (int i = 3; i <= 16; i++) exp_q.push_back(DW'(i));
    exp_q.push_back(24'h21);
    foreach (exp_q[i]) begin
      chk($sformatf("drain%0d_data", i), 32'(d_data), 32'(exp_q[i]));
      chk($sformatf("bp_drain%0d_data", i), 32'(b_data), 32'(exp_q[i]));
      cyc(0, 0, 1, 0, 0);
    end
    chk("drain_valid", 32'(d_vld), 0);
    chk("drain_level", 32'(d_lvl), 0);
    chk("drain_data_zero", 32'(d_data), 0);

    // Pointer wrap and flush-vs-push
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, DW'(24'h100 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, DW'(24'h200 + i), 0, 0, 0);
    chk("wrap_level", 32'(d_lvl), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("wrap%0d_data", i), 32'(d_data), 32'(24'h200 + i));
      cyc(0, 0, 1, 0, 0);
    end
    chk("wrap_empty", 32'(d_vld), 0);
    for (int i = 0; i < 3; i++) cyc(1, DW'(24'h300 + i), 0, 0, 0);
    cyc(1, 24'h3FF, 0, 1, 0);
    chk("flush_level", 32'(d_lvl), 0);
    chk("flush_valid", 32'(d_vld), 0);
    chk("flush_drop", 32'(d_drop), 0);
    cyc(1, 24'h400, 0, 0, 0);
    chk("post_flush_head", 32'(d_data), 32'h400);

    // Async reset between edges
    for (int i = 0; i < 6; i++) cyc(1, DW'(24'h500 + i), 0, 0, 0);
    chk("pre_rst_level", 32'(d_lvl), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_level", 32'(d_lvl), 0);
    chk("async_rst_valid", 32'(d_vld), 0);
    chk("async_rst_data", 32'(d_data), 0);
    #1 rst_n = 1'b1;
    cyc(1, 24'hABC, 0, 0, 0);
    chk("post_rst_valid", 32'(d_vld), 1);
    chk("post_rst_data", 32'(d_data), 32'hABC);
    chk("post_rst_level", 32'(d_lvl), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
